// File: rtl/key_tx_pkg.sv
// key_tx_pkg: shared constants for the key event transmitter.
//   - key bit indices in the `keys` vector (bit 7 = up ... bit 0 = atk)
//   - ASCII codes sent for presses, and the offset/code used for releases
//   - serializer state encoding
//   - helpers: top_bit() (highest set bit), press_code()/release_code()
package key_tx_pkg;

  localparam int KEY_UP    = 7;
  localparam int KEY_DOWN  = 6;
  localparam int KEY_LEFT  = 5;
  localparam int KEY_RIGHT = 4;
  localparam int KEY_J     = 3;
  localparam int KEY_K     = 2;
  localparam int KEY_L     = 1;
  localparam int KEY_ATK   = 0;

  localparam logic [7:0] ASCII_W     = 8'h77;
  localparam logic [7:0] ASCII_S     = 8'h73;
  localparam logic [7:0] ASCII_A     = 8'h61;
  localparam logic [7:0] ASCII_D     = 8'h64;
  localparam logic [7:0] ASCII_J     = 8'h6A;
  localparam logic [7:0] ASCII_K     = 8'h6B;
  localparam logic [7:0] ASCII_L     = 8'h6C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [7:0] REL_OFFSET   = 8'h20;
  localparam logic [7:0] ATK_REL_CODE = 8'h5A;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  // Index of the highest set bit; 0 when v is empty (caller gates on |v).
  function automatic logic [2:0] top_bit(input logic [7:0] v);
    top_bit = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) top_bit = 3'(i);
  endfunction

  function automatic logic [7:0] press_code(input logic [2:0] i);
    case (i)
      3'(KEY_UP):    press_code = ASCII_W;
      3'(KEY_DOWN):  press_code = ASCII_S;
      3'(KEY_LEFT):  press_code = ASCII_A;
      3'(KEY_RIGHT): press_code = ASCII_D;
      3'(KEY_J):     press_code = ASCII_J;
      3'(KEY_K):     press_code = ASCII_K;
      3'(KEY_L):     press_code = ASCII_L;
      default:       press_code = ASCII_SPACE;
    endcase
  endfunction

  // Uppercase of the press letter; space has no uppercase so atk uses 'Z'.
  function automatic logic [7:0] release_code(input logic [2:0] i);
    release_code = (i == 3'(KEY_ATK)) ? ATK_REL_CODE : press_code(i) - REL_OFFSET;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 LSB-first UART transmitter.
//   CLK, RESET (async, active low)
//   load      in  start a frame with `data`; only honoured in IDLE
//   data[7:0] in  byte to send
//   TX        out serial line, idles high (registered)
//   busy      out high whenever the FSM is not in IDLE (registered)
module uart_tx_serializer
  import key_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [7:0] data,
  output logic       TX,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          wrap;

  assign wrap = (cnt == CW'(CLKS_PER_BIT - 1));

  // TX is driven one edge ahead of each bit so the line changes exactly
  // on the state transition edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      TX    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (load) begin
          state <= S_START;
          shreg <= data;
          cnt   <= '0;
          idx   <= '0;
          TX    <= 1'b0;
          busy  <= 1'b1;
        end
        S_START: if (wrap) begin
          cnt   <= '0;
          state <= S_DATA;
          TX    <= shreg[0];
        end else cnt <= cnt + 1'b1;
        S_DATA: if (wrap) begin
          cnt <= '0;
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            state <= S_STOP;
            TX    <= 1'b1;
          end else TX <= shreg[idx + 3'd1];
        end else cnt <= cnt + 1'b1;
        S_STOP: if (wrap) begin
          cnt   <= '0;
          state <= S_IDLE;
          busy  <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= S_IDLE;
          TX    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_tx.sv
// key_event_tx: sends one ASCII byte per key press over an 8N1 UART line.
//   CLK, RESET (async, active low)
//   keys[7:0]    in  level key vector {up,down,left,right,j,k,l,atk}
//   TX           out serial output, idles high
//   busy         out serializer not idle
//   pending[7:0] out presses latched but not yet handed to the serializer
// Optional: define KEY_TX_RELEASE_EN to also send releases (uppercase,
// atk -> 'Z'); releases always yield to pending presses.
module key_event_tx
  import key_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] keys,
  output logic       TX,
  output logic       busy,
  output logic [7:0] pending
);

  logic [7:0] keys_q;
  logic       armed;   // low for the first cycle after reset: keys_q primes only
  logic [7:0] press, clr;
  logic [2:0] sel;
  logic       load;
  logic [7:0] data;

  assign press = armed ? (keys & ~keys_q) : 8'h00;

`ifdef KEY_TX_RELEASE_EN
  logic [7:0] rel_pending, rel, rclr;
  logic [2:0] rsel;
  assign rel = armed ? (~keys & keys_q) : 8'h00;
`endif

  // Fixed-priority pick; busy low is exactly the serializer's IDLE state.
  always_comb begin
    load = 1'b0;
    data = 8'h00;
    clr  = 8'h00;
    sel  = top_bit(pending);
`ifdef KEY_TX_RELEASE_EN
    rclr = 8'h00;
    rsel = top_bit(rel_pending);
`endif
    if (!busy && |pending) begin
      load = 1'b1;
      clr  = 8'h01 << sel;
      data = press_code(sel);
    end
`ifdef KEY_TX_RELEASE_EN
    else if (!busy && |rel_pending) begin
      load = 1'b1;
      rclr = 8'h01 << rsel;
      data = release_code(rsel);
    end
`endif
  end

  // Clear before set: a fresh press on the load edge keeps the bit pending.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      keys_q  <= 8'h00;
      armed   <= 1'b0;
      pending <= 8'h00;
`ifdef KEY_TX_RELEASE_EN
      rel_pending <= 8'h00;
`endif
    end else begin
      keys_q  <= keys;
      armed   <= 1'b1;
      pending <= (pending & ~clr) | press;
`ifdef KEY_TX_RELEASE_EN
      rel_pending <= (rel_pending & ~rclr) | rel;
`endif
    end
  end

  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .CLK  (CLK),
    .RESET(RESET),
    .load (load),
    .data (data),
    .TX   (TX),
    .busy (busy)
  );

endmodule

// File: doc/key_event_tx.md
# key_event_tx

Transmit-side counterpart of the UART key receiver: watches the 8-bit game key vector and sends one ASCII byte over the serial line (8N1, LSB first) for every key press. Sits between the game logic or key source and the FPGA `TX` pin, producing the same character set the receiver decodes. This gives the host or the peer board a live key-event stream.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per serial bit (100 MHz / 9600 baud); legal values are ≥ 2.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `keys`  in  8  level key vector, `{up, down, left, right, j, k, l, atk}`, with bit 7 = up; synchronous to `CLK`.
- `TX`  out  1  serial output; idles high.
- `busy`  out  1  high while the serializer is not in IDLE.
- `pending`  out  8  press events latched but not yet loaded into the serializer, same bit order as `keys`.

## Operation
- **Edge detect:** `keys_q` holds `keys` from the previous cycle. A press is `keys & ~keys_q`. Each press bit sets the matching `pending` bit.
- **Character map:**
  - bit7 → `0x77` ('w'), bit6 → `0x73` ('s'), bit5 → `0x61` ('a'), bit4 → `0x64` ('d')
  - bit3 → `0x6A` ('j'), bit2 → `0x6B` ('k'), bit1 → `0x6C` ('l'), bit0 → `0x20` (space)
- **Arbiter:** fixed priority, highest set `pending` bit first, so bit 7 wins.
- **Load:** in IDLE with `pending != 0`, the selected byte is latched and its `pending` bit clears on the same edge.
  - If a new press of that same key arrives on that edge, the set wins and the bit stays pending.
- **Repeated presses:** a press of a key whose bit is already pending is absorbed, so one byte goes out.
- **Serializer FSM:** IDLE → START → DATA → STOP → IDLE.
  - START drives `TX`=0 for `CLKS_PER_BIT` cycles.
  - DATA drives bit `idx` (0..7, LSB first) for `CLKS_PER_BIT` cycles each.
  - STOP drives `TX`=1 for `CLKS_PER_BIT` cycles.
- **Counters:** the baud counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. The 3-bit bit index advances on the wrap and leaves DATA when it wraps from 7.
- **Reset values:** `TX`=1, `busy`=0, `pending`=0, `keys_q`=0, state IDLE, both counters 0.
  - Reset asserted mid-frame aborts the frame immediately and drops all pending events.
  - Keys already held when reset releases do not generate presses until they are released and pressed again. This means `keys_q` loads `keys` on the first cycle after reset release, with no edge evaluated on that cycle.

## Timing
- **Latency:** `keys` rises before edge n → `pending` set at edge n → state START and `TX`=0 at edge n+1, when idle.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles, from START entry to IDLE entry.
- **Back-to-back frames:** exactly one IDLE cycle between a STOP end and the next START, so the inter-frame gap is `CLKS_PER_BIT`+1 cycles of high line.
- **`busy`:** registered; rises on the START edge and falls on the IDLE-entry edge.
- **`pending` bit reflection:**
  - A press captured during a frame is visible on `pending` from the next edge.
  - A bit drops on its load edge.

## Configuration
- **`KEY_TX_RELEASE_EN` defined:** falling edges (`~keys & keys_q`) are also reported.
  - They go into a second internal 8-bit release-pending vector.
  - Release bytes are the press code − `0x20` (uppercase); atk release sends `0x5A` ('Z').
  - All press events have priority over all release events.
  - Press and release of the same key in the same cycle cannot occur.
- **`KEY_TX_RELEASE_EN` undefined:** releases are ignored and the release vector and its mux are absent.

## Structure
- **Package `key_tx_pkg`:** key bit index constants (`KEY_UP`=7 … `KEY_ATK`=0), the 8 ASCII codes, the release offset `0x20`, the atk release code `0x5A`, and the FSM state enum.
- **Sub-module `uart_tx_serializer`:** owns the FSM, baud counter, bit index and `TX`.
  - Parameter `CLKS_PER_BIT`.
  - Handshake `load`/`data[7:0]` in, `busy` out; `load` is only honoured in IDLE.
- **Top level:** keeps edge detect, the pending vectors and the arbiter.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Single press:** raise `keys[7]` for one cycle → `TX` shows 0, 1,1,1,0,1,1,1,0 (LSB-first `0x77`), then 1, each bit 4 cycles. START is 2 edges after the rise. `busy` is high for 40 cycles.
- **Simultaneous presses:** raise `keys[7]` and `keys[0]` together → frames `0x77` then `0x20`, separated by exactly 5 high cycles.
- **Press during a frame, plus repeats:**
  - Press `keys[2]` mid-frame → `pending`=`0x04` until that frame ends, then a `0x6B` frame follows.
  - Pulse `keys[2]` 3 times during the same frame → only one `0x6B` frame follows.
- **Reset mid-frame:** assert `RESET` low in DATA with `pending`=`0x10` → `TX`=1, `busy`=0 and `pending`=0 asynchronously.
  - With `keys[4]` held through release, no frame is sent.
- **Release enabled:** with `KEY_TX_RELEASE_EN`, press then release `keys[0]` → frames `0x20` then `0x5A`.
  - Without the macro, only `0x20` is sent.
